// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package seq_chunk_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the slice index; kept at least one bit so a single-chunk
   // configuration still has a legal counter.
   function automatic int unsigned idx_width(input int unsigned nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry out and carry into its MSB.
module chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int unsigned CHUNK = 4
) (
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb,
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin
);

   // Sum the slice; the carry into the MSB is recovered from the MSB sum bit
   // so that CHUNK=1 needs no special case.
   always_comb begin
      {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
      cmsb      = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-bit slice per clock with a
// carry register between slices and valid/ready handshakes on both sides.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] x_slice, y_slice, s_slice;
   logic             c_slice, cmsb_slice;

   // Select the operand slice addressed by the current index.
   always_comb begin
      x_slice = a_q[idx_q*CHUNK +: CHUNK];
      y_slice = b_q[idx_q*CHUNK +: CHUNK];
   end

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .s    (s_slice),
      .cout (c_slice),
      .cmsb (cmsb_slice),
      .x    (x_slice),
      .y    (y_slice),
      .cin  (carry_q)
   );

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is a + ~b + ~borrow, so both are inverted here.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~carry_in : carry_in;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*CHUNK +: CHUNK] = s_slice;
            carry_d = c_slice;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = c_slice;
               ovf_d   = cmsb_slice ^ c_slice;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised N-bit adder/subtractor for the Mini-MIPS datapath.
- Processes one CHUNK-bit slice per clock, ripple-carrying between slices through a carry register.
- Uses a valid/ready handshake on both input and output.
- Provides signed overflow and an add/subtract mode.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands, carry_in and sub are valid
- in_ready  output  1  block can accept a new operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry in (add) / borrow in (sub)
- sub  input  1  0: a+b+carry_in; 1: a-b-carry_in
- out_valid  output  1  result fields valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry_out  output  1  carry out of MSB (raw adder carry, also in sub mode)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0. Chunk counter and carry register cleared. Reset mid-RUN or mid-DONE aborts the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b_eff=sub?~b:b, carry=sub?~carry_in:carry_in, idx=0, go to RUN.
  - RUN: in_ready=0. Each cycle add slice idx of a and b_eff plus carry, write sum slice idx, update carry, idx++.
  - DONE: entered after slice NCHUNK-1 with out_valid=1. Outputs held stable until out_ready=1, then return to IDLE with out_valid=0.
- NCHUNK = WIDTH/CHUNK. Accept at edge k: out_valid high from edge k+NCHUNK. Busy for NCHUNK cycles plus the stall while out_ready=0.
- No new operation is accepted in the same cycle as a result handoff. The next accept occurs at the earliest one cycle after the DONE to IDLE transition.
- carry_out: carry out of the final slice.
- overflow = carry into MSB XOR carry out of MSB, computed in the final slice.
- sum, carry_out and overflow update only in RUN and DONE. They are undefined-free (hold the last values) in IDLE.
- in_valid in RUN or DONE is ignored. Operands are sampled only at accept.
- WIDTH==CHUNK is legal: single RUN cycle, latency 1.

Decomposition:
- Shared package/header holds the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NCHUNK/index-width derivation (clog2).
- One sub-module: chunk_adder, a combinational CHUNK-bit adder with ports (s, cout, cmsb, x, y, cin), where cmsb is the carry into its MSB. It is instantiated once and muxed by idx.

Test Plan:
- Add, defaults: a=16'h00FF, b=16'h0001, carry_in=0, sub=0 -> out_valid 4 cycles after accept; sum=16'h0100, carry_out=0, overflow=0.
- Carry/overflow: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, overflow=1, carry_out=0. Then a=16'hFFFF, b=16'h0001 -> sum=16'h0000, carry_out=1, overflow=0.
- Subtract with borrow: a=16'h0005, b=16'h0003, carry_in=1, sub=1 -> sum=16'h0001, carry_out=1. Then a=16'h8000, b=16'h0001, cin=0 -> sum=16'h7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum stable, in_ready=0, a second in_valid is ignored. Release -> one handoff, then in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> next cycle in_ready=1, out_valid=0, sum=0. A following op a=16'h0003, b=16'h0004 yields sum=16'h0007.
- Parameter sweep: WIDTH=8, CHUNK=8 (latency 1) and WIDTH=32, CHUNK=4 (latency 8), each with 200 random ops checked against an a±b±cin reference model.
